// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register.
//   pipe_state_e : occupancy state of a stage register (EMPTY / ONE / FULL)
//   *_DATA_W/_CTRL_W : bundle widths of the standard stage registers
//   pack_ctrl()  : assembles the common control fields into a CTRL bundle
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  // Datapath bundles: IF/ID carries pc, pc+4, instr; later stages add operands/results.
  localparam int unsigned IFID_DATA_W  = 96;
  localparam int unsigned IFID_CTRL_W  = 16;
  localparam int unsigned IDEX_DATA_W  = 160;
  localparam int unsigned IDEX_CTRL_W  = 16;
  localparam int unsigned EXMEM_DATA_W = 160;
  localparam int unsigned EXMEM_CTRL_W = 16;
  localparam int unsigned MEMWB_DATA_W = 128;
  localparam int unsigned MEMWB_CTRL_W = 16;

  // Layout: [15:11] reserved, [10:6] rd, [5:3] dram op, [2:1] wb select, [0] reg write enable.
  function automatic logic [15:0] pack_ctrl(input logic       reg_we,
                                            input logic [1:0] wb_sel,
                                            input logic [2:0] dram_op,
                                            input logic [4:0] rd);
    return {5'b0, rd, dram_op, wb_sel, reg_we};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages and the stage register.
//   master : upstream/downstream environment (drives in_*, out_ready, flush)
//   slave  : the stage register (drives in_ready, out_*, occupancy, stall_cnt)
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              flush;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready, flush,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready, flush,
    output in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
  );

endinterface

// File: rtl/pipe_entry.sv
// One storage slot of the stage register: payload plus its own valid bit.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : synchronous clear of payload and valid (highest priority)
//   load_i   : capture d_i and mark valid
//   drop_i   : mark invalid, payload kept
//   d_i/q_o  : payload in/out; valid_o : slot holds an entry
module pipe_entry #(
  parameter int unsigned W = 176
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         drop_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         valid_o
);

  logic [W-1:0] data_q;
  logic         valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clr_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= d_i;
      valid_q <= 1'b1;
    end else if (drop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and a saturating stall counter.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of pipe_stage_reg_if (in_* handshake, out_* handshake,
//              flush, occupancy, stall_cnt)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_stage_reg_if.slave        bus
);

  localparam int unsigned EntW = DATA_W + CTRL_W;

  pipe_state_e      state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic            in_ready, out_valid;
  logic            up_xfer, dn_xfer;
  logic            clr, main_load, main_drop, main_from_skid, skid_load, skid_drop;
  logic [EntW-1:0] in_ent, main_d, main_q, skid_q;
  logic            main_vld, skid_vld;

  // Handshake flags depend only on registered state: no out_ready -> in_ready path.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign up_xfer   = bus.in_valid && in_ready;
  assign dn_xfer   = out_valid && bus.out_ready;
  assign in_ent    = {bus.in_data, bus.in_ctrl};
  assign main_d    = main_from_skid ? skid_q : in_ent;

  always_comb begin
    state_d        = state_q;
    clr            = 1'b0;
    main_load      = 1'b0;
    main_drop      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    if (bus.flush) begin
      // Flush wins over both transfers; the offered entry is dropped.
      state_d = EMPTY;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (up_xfer) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (up_xfer && dn_xfer) begin
            main_load = 1'b1;
          end else if (up_xfer) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (dn_xfer) begin
            state_d   = EMPTY;
            main_drop = 1'b1;
          end
        end
        FULL: begin
          if (dn_xfer) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_drop      = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
          clr     = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  pipe_entry #(
    .W(EntW)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .load_i (main_load),
    .drop_i (main_drop),
    .d_i    (main_d),
    .q_o    (main_q),
    .valid_o(main_vld)
  );

  pipe_entry #(
    .W(EntW)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .load_i (skid_load),
    .drop_i (skid_drop),
    .d_i    (in_ent),
    .q_o    (skid_q),
    .valid_o(skid_vld)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q[EntW-1:CTRL_W];
  // A bubble must never carry live control bits downstream.
  assign bus.out_ctrl  = out_valid ? main_q[CTRL_W-1:0] : '0;
  assign bus.occupancy = {1'b0, main_vld} + {1'b0, skid_vld};
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int unsigned DW = 160;
  localparam int unsigned CW = 16;
  localparam int unsigned NW = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];
  ent_t mon_e;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) bus ();

  pipe_stage_reg #(
    .DATA_W(DW),
    .CTRL_W(CW),
    .CNT_W (NW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Scoreboard monitor: every downstream transfer must match the next expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got data=%0h ctrl=%0h, required no output",
                   bus.out_data, bus.out_ctrl);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.out_data !== mon_e.d || bus.out_ctrl !== mon_e.c) begin
            errors++;
            $display("FAIL out_order: got data=%0h ctrl=%0h, required data=%0h ctrl=%0h",
                     bus.out_data, bus.out_ctrl, mon_e.d, mon_e.c);
          end
        end
      end
      if (!bus.out_valid) begin
        checks++;
        if (bus.out_ctrl !== '0) begin
          errors++;
          $display("FAIL bubble_ctrl: got %0h, required 0", bus.out_ctrl);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [175:0] act, input logic [175:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an entry that the directed sequence expects to reach the output.
  task automatic offer(input logic [DW-1:0] d, input logic [CW-1:0] c);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_ctrl  = c;
    exp_q.push_back({d, c});
  endtask

  // Offer an entry that the directed sequence expects to be discarded.
  task automatic drive(input logic [DW-1:0] d, input logic [CW-1:0] c);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_ctrl  = c;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ctrl   = '0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;

    // Reset values
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 176'(bus.out_valid), 176'd0);
    chk("rst_in_ready", 176'(bus.in_ready), 176'd1);
    chk("rst_out_data", 176'(bus.out_data), 176'd0);
    chk("rst_out_ctrl", 176'(bus.out_ctrl), 176'd0);
    chk("rst_occupancy", 176'(bus.occupancy), 176'd0);
    chk("rst_stall_cnt", 176'(bus.stall_cnt), 176'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Stream 1..5 with out_ready=1: one-cycle latency, full throughput
    for (int i = 1; i <= 5; i++) begin
      offer(DW'(i), 16'(16'h1000 + i));
      @(negedge clk);
      chk("stream_in_ready", 176'(bus.in_ready), 176'd1);
      if (i > 1) begin
        chk("stream_out_valid", 176'(bus.out_valid), 176'd1);
        chk("stream_out_data", 176'(bus.out_data), 176'(i - 1));
      end
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_data", 176'(bus.out_data), 176'd5);
    tick();
    @(negedge clk);
    chk("stream_occ_idle", 176'(bus.occupancy), 176'd0);
    chk("stream_stall_cnt", 176'(bus.stall_cnt), 176'd0);
    tick();

    // Single stall while 10 is at the head
    offer(DW'(10), 16'h2010);
    tick();
    bus.out_ready = 1'b0;
    offer(DW'(11), 16'h2011);
    @(negedge clk);
    chk("stall_in_ready_one", 176'(bus.in_ready), 176'd1);
    chk("stall_occ_one", 176'(bus.occupancy), 176'd1);
    tick();
    bus.out_ready = 1'b1;
    offer(DW'(12), 16'h2012);
    @(negedge clk);
    chk("stall_occ_full", 176'(bus.occupancy), 176'd2);
    chk("stall_in_ready_full", 176'(bus.in_ready), 176'd0);
    chk("stall_head_10", 176'(bus.out_data), 176'd10);
    chk("stall_cnt_one", 176'(bus.stall_cnt), 176'd1);
    tick();
    @(negedge clk);
    chk("stall_in_ready_back", 176'(bus.in_ready), 176'd1);
    chk("stall_head_11", 176'(bus.out_data), 176'd11);
    tick();
    bus.in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("stall_occ_drained", 176'(bus.occupancy), 176'd0);
    chk("stall_cnt_final", 176'(bus.stall_cnt), 176'd1);
    tick();

    // Flush while FULL with a colliding offer of 22
    bus.out_ready = 1'b0;
    drive(DW'(20), 16'h00AA);
    tick();
    drive(DW'(21), 16'h00BB);
    tick();
    drive(DW'(22), 16'h00CC);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_occ_before", 176'(bus.occupancy), 176'd2);
    chk("flush_in_ready_before", 176'(bus.in_ready), 176'd0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 176'(bus.out_valid), 176'd0);
    chk("flush_out_ctrl", 176'(bus.out_ctrl), 176'd0);
    chk("flush_out_data", 176'(bus.out_data), 176'd0);
    chk("flush_occupancy", 176'(bus.occupancy), 176'd0);
    chk("flush_in_ready", 176'(bus.in_ready), 176'd1);
    chk("flush_keeps_stall_cnt", 176'(bus.stall_cnt), 176'd3);
    tick();
    bus.out_ready = 1'b1;
    repeat (3) tick();

    // Stall counter saturation at 2^4-1
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    chk("sat_cleared", 176'(bus.stall_cnt), 176'd0);
    bus.out_ready = 1'b0;
    offer(DW'(30), 16'h0030);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10) chk("sat_mid", 176'(bus.stall_cnt), 176'd10);
    end
    chk("sat_final", 176'(bus.stall_cnt), 176'd15);
    bus.out_ready = 1'b1;
    tick();
    tick();

    // Asynchronous reset while FULL
    bus.out_ready = 1'b0;
    drive(DW'(40), 16'h0040);
    tick();
    drive(DW'(41), 16'h0041);
    tick();
    bus.in_valid = 1'b0;
    chk("arst_full_before", 176'(bus.occupancy), 176'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 176'(bus.out_valid), 176'd0);
    chk("arst_in_ready", 176'(bus.in_ready), 176'd1);
    chk("arst_occupancy", 176'(bus.occupancy), 176'd0);
    chk("arst_stall_cnt", 176'(bus.stall_cnt), 176'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();

    // Bubbles with all-ones control on the input
    bus.in_valid = 1'b0;
    bus.in_ctrl  = 16'hFFFF;
    bus.in_data  = DW'(99);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bubble_out_ctrl", 176'(bus.out_ctrl), 176'd0);
      chk("bubble_out_valid", 176'(bus.out_valid), 176'd0);
      tick();
    end

    chk("scoreboard_drained", 176'(exp_q.size()), 176'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and a stall-cycle counter. It is the generic successor to the fixed-field stage registers. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). With it, a stage can apply backpressure and squash wrong-path instructions without losing or duplicating entries.

## Interface
Parameters:
- DATA_W, 160: width of the datapath bundle (PC, PC+4, instruction, operands, ALU result, ...).
- CTRL_W, 16: width of the control bundle (write enable, write-back select, DRAM op, ...).
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage can accept an entry.
- in_data  in  DATA_W  upstream datapath bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  held entry is valid; replaces the have_inst flag.
- out_ready  in  1  downstream consumes the entry.
- out_data  out  DATA_W  head datapath bundle.
- out_ctrl  out  CTRL_W  head control bundle; zero whenever out_valid=0.
- flush  in  1  squash every held entry and any entry offered this cycle.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

## Operation
- Transfer rules:
  - An upstream transfer occurs when in_valid && in_ready.
  - A downstream transfer occurs when out_valid && out_ready.
- Storage: a main entry (the head) and a skid entry. Each entry has its own valid bit.
- States (enum in the package):
  - EMPTY: no entries held.
  - ONE: main entry valid.
  - FULL: main and skid entries valid.
- State transitions (no flush):
  - EMPTY + upstream transfer -> ONE; the input is written to main.
  - ONE + upstream transfer + downstream transfer -> ONE; main is overwritten by the input.
  - ONE + upstream transfer only -> FULL; the input is written to skid.
  - ONE + downstream transfer only -> EMPTY.
  - FULL + downstream transfer -> ONE; skid moves to main. No upstream transfer is possible in FULL.
  - All other cases: hold.
- in_ready = (state != FULL). It is a function of registered state only and has no combinational path from out_ready.
- out_valid = (state != EMPTY). out_data and out_ctrl always present the main entry.
- Flush:
  - Next state is EMPTY.
  - Both valid bits clear; main and skid data/ctrl are cleared to zero.
  - Flush overrides any simultaneous upstream or downstream transfer. The offered input is dropped; the upstream stage sees in_ready as driven by the current state.
- Control zeroing: out_ctrl is forced to 0 while out_valid=0, so a bubble can never write the register file or memory.
- stall_cnt:
  - Increments when out_valid && !out_ready; saturates at 2^CNT_W-1.
  - Not cleared by flush; cleared only by rst.
- Width rules: data and ctrl are stored verbatim. Sign and width interpretation belongs to the consumers.

## Timing
- Reset (asynchronous, active-high), all outputs:
  - state = EMPTY
  - out_valid = 0
  - in_ready = 1
  - out_data = 0
  - out_ctrl = 0
  - occupancy = 0
  - stall_cnt = 0
- Latency: an entry accepted on edge N is visible on out_* after edge N (one cycle).
- Throughput: one entry per cycle while out_ready=1.
- Backpressure:
  - out_ready low for one cycle with input streaming: one entry lands in skid, and in_ready drops the following cycle.
  - After out_ready returns, in_ready rises one cycle after the FULL->ONE drain.
- No entry is lost or duplicated. Order is strictly FIFO.
- rst asserted mid-operation: state returns to EMPTY immediately, independent of clk. Any in-flight entries are discarded.

## Structure
- Package pipe_pkg holds:
  - the state enum pipe_state_e {EMPTY, ONE, FULL};
  - localparam widths for the standard stage bundles (e.g. EXMEM_DATA_W, EXMEM_CTRL_W);
  - a helper that packs control fields into ctrl bundles.
- One sub-module is natural: pipe_entry. It is a DATA_W+CTRL_W register with a valid bit, a load enable and a synchronous clear. It is instantiated twice, as main and skid.
- The FSM and the counter live in the top-level module.

## Test plan
- Reset then stream: rst pulse, then in_valid=1 with in_data=1,2,3,... and out_ready=1 -> out_data=1 on the cycle after the first accept, followed by 2,3,... back to back; stall_cnt=0.
- Single stall: streaming 10,11,12 with out_ready=0 for one cycle on the beat where 10 is at the head -> occupancy=2 (10 in main, 11 in skid); in_ready=0 for one cycle; output order 10,11,12; stall_cnt=1.
- Flush with collision: FULL holding 20,21, in_valid=1 with data 22, flush=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 22 never appears.
- Saturation: CNT_W=4, out_valid held with out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- Async reset mid-stream: rst asserted between edges while FULL -> out_valid=0, in_ready=1 and occupancy=0 before the next edge.
- Bubble safety: in_valid=0 and in_ctrl=16'hFFFF for 5 cycles -> out_ctrl stays 0 throughout.
